// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: accepts a multi-hot request vector and
// emits the index of every set bit, one beat per handshake, in priority order.
module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_vec_q, zero_vec_d;

  logic [IDXW-1:0]  pri_idx;
  logic             one_hot;
  logic             scanning;
  logic             beat_done;
  logic             accept;

  // Pick the highest-priority pending bit; the last match in loop order wins
  always_comb begin
    pri_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (pending_q[i]) pri_idx = IDXW'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (pending_q[i]) pri_idx = IDXW'(i);
    end
  end

  // Handshake and output decode, all from registered state
  always_comb begin
    scanning  = (state_q == SCAN);
    one_hot   = (pending_q != '0) &&
                ((pending_q & (pending_q - WIDTH'(1))) == '0);
    out_valid = scanning;
    out_idx   = scanning ? pri_idx : '0;
    out_last  = scanning && (zero_vec_q || one_hot);
    out_none  = scanning && zero_vec_q;
    busy      = scanning;
    beat_done = out_valid && out_ready;
    in_ready  = !rst && enable &&
                (!scanning || (beat_done && out_last));
    accept    = in_valid && in_ready;
  end

  // Next-state: retire the emitted bit, finish on last beat, or reload
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_vec_d = zero_vec_q;
    if (beat_done) begin
      pending_d = pending_q & ~(WIDTH'(1) << pri_idx);
      if (out_last) state_d = IDLE;
    end
    if (accept) begin
      pending_d  = in_data;
      zero_vec_d = (in_data == '0);
      state_d    = SCAN;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_vec_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_vec_q <= zero_vec_d;
    end
  end

endmodule
